// File: rtl/bisr_pkg.sv
// Shared definitions for the data buffer loader and the data buffer it feeds.
//   - state_e    : loader FSM states
//   - DefRows/DefCols/DefWordSize : default tile geometry and word width
package bisr_pkg;

  localparam int unsigned DefRows     = 3;
  localparam int unsigned DefCols     = 3;
  localparam int unsigned DefWordSize = 16;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StLoad = 2'd1,
    StDone = 2'd2
  } state_e;

endpackage

// File: rtl/raster_counter.sv
// Raster-order row/column address counter for one ROWS x COLS tile.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   clr_i      : synchronous clear to (0,0); wins over adv_i
//   adv_i      : advance one position (col first, then row)
//   row_o/col_o: current address
//   last_o     : current address is (ROWS-1, COLS-1)
module raster_counter
  import bisr_pkg::*;
#(
  parameter int unsigned ROWS = DefRows,
  parameter int unsigned COLS = DefCols
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            clr_i,
  input  logic            adv_i,
  output logic [ROWS-1:0] row_o,
  output logic [COLS-1:0] col_o,
  output logic            last_o
);

  localparam int unsigned RowMaxI = ROWS - 1;
  localparam int unsigned ColMaxI = COLS - 1;
  localparam int unsigned OneI    = 1;
  localparam logic [ROWS-1:0] RowMax = RowMaxI[ROWS-1:0];
  localparam logic [COLS-1:0] ColMax = ColMaxI[COLS-1:0];
  localparam logic [ROWS-1:0] RowOne = OneI[ROWS-1:0];
  localparam logic [COLS-1:0] ColOne = OneI[COLS-1:0];

  logic [ROWS-1:0] row_q, row_d;
  logic [COLS-1:0] col_q, col_d;
  logic            col_wrap;

  assign col_wrap = (col_q == ColMax);
  assign last_o   = (row_q == RowMax) && col_wrap;
  assign row_o    = row_q;
  assign col_o    = col_q;

  always_comb begin
    row_d = row_q;
    col_d = col_q;
    if (clr_i) begin
      row_d = '0;
      col_d = '0;
    end else if (adv_i && !last_o) begin
      // Saturate at the last address; the FSM leaves LOAD on that beat.
      if (col_wrap) begin
        col_d = '0;
        row_d = row_q + RowOne;
      end else begin
        col_d = col_q + ColOne;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      row_q <= '0;
      col_q <= '0;
    end else begin
      row_q <= row_d;
      col_q <= col_d;
    end
  end

endmodule

// File: rtl/data_buffer_loader.sv
// Streams one ROWS x COLS tile of words from a valid/ready source into the
// data buffer write port, in raster order, one write per accepted beat.
// Ports:
//   clk, rst_n        : clock, asynchronous active-low reset
//   start             : pulse, begins a tile load (only honoured in IDLE)
//   abort             : cancels a load in progress
//   in_valid, in_data : upstream word; in_ready is the combinational accept
//   we, row, col, data: registered data buffer write port
//   busy              : loading; done: one-cycle pulse with the final write
//   err               : sticky, a word was offered while not loading
module data_buffer_loader
  import bisr_pkg::*;
#(
  parameter int unsigned ROWS      = DefRows,
  parameter int unsigned COLS      = DefCols,
  parameter int unsigned WORD_SIZE = DefWordSize
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic                 abort,
  input  logic                 in_valid,
  input  logic [WORD_SIZE-1:0] in_data,
  output logic                 in_ready,
  output logic                 we,
  output logic [ROWS-1:0]      row,
  output logic [COLS-1:0]      col,
  output logic [WORD_SIZE-1:0] data,
  output logic                 busy,
  output logic                 done,
  output logic                 err
);

  state_e state_q, state_d;

  logic                 accept;
  logic                 cnt_clr;
  logic                 cnt_last;
  logic [ROWS-1:0]      cnt_row;
  logic [COLS-1:0]      cnt_col;

  logic                 we_q;
  logic [ROWS-1:0]      row_q;
  logic [COLS-1:0]      col_q;
  logic [WORD_SIZE-1:0] data_q;
  logic                 err_q, err_d;

  // Abort masks ready so a beat offered alongside it is never taken.
  assign in_ready = (state_q == StLoad) && !abort;
  assign accept   = in_valid && in_ready;

  raster_counter #(
    .ROWS (ROWS),
    .COLS (COLS)
  ) u_raster_counter (
    .clk    (clk),
    .rst_n  (rst_n),
    .clr_i  (cnt_clr),
    .adv_i  (accept),
    .row_o  (cnt_row),
    .col_o  (cnt_col),
    .last_o (cnt_last)
  );

  always_comb begin
    state_d = state_q;
    cnt_clr = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          state_d = StLoad;
          cnt_clr = 1'b1;
        end
      end
      StLoad: begin
        if (abort) begin
          state_d = StIdle;
          cnt_clr = 1'b1;
        end else if (accept && cnt_last) begin
          state_d = StDone;
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // A start that is honoured clears err and masks a same-cycle set.
  always_comb begin
    err_d = err_q;
    if (start && (state_q == StIdle)) begin
      err_d = 1'b0;
    end else if (in_valid && (state_q != StLoad)) begin
      err_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      we_q    <= 1'b0;
      row_q   <= '0;
      col_q   <= '0;
      data_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      we_q    <= accept;
      err_q   <= err_d;
      if (accept) begin
        row_q  <= cnt_row;
        col_q  <= cnt_col;
        data_q <= in_data;
      end
    end
  end

  assign we   = we_q;
  assign row  = row_q;
  assign col  = col_q;
  assign data = data_q;
  assign busy = (state_q == StLoad);
  // DONE is entered on the final accepted beat, so it lines up with its write.
  assign done = (state_q == StDone);
  assign err  = err_q;

endmodule

// File: tb/tb_data_buffer_loader.sv
// Directed bench for data_buffer_loader with the default 3x3x16 geometry.
module tb_data_buffer_loader;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic        abort;
  logic        in_valid;
  logic [15:0] in_data;
  logic        in_ready;
  logic        we;
  logic [2:0]  row;
  logic [2:0]  col;
  logic [15:0] data;
  logic        busy;
  logic        done;
  logic        err;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  data_buffer_loader dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .abort    (abort),
    .in_valid (in_valid),
    .in_data  (in_data),
    .in_ready (in_ready),
    .we       (we),
    .row      (row),
    .col      (col),
    .data     (data),
    .busy     (busy),
    .done     (done),
    .err      (err)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Check the registered write port and done after an edge.
  task automatic chk_wr(input string tag, input logic exp_we, input int r, input int c,
                        input logic [15:0] d, input logic exp_done);
    chk({tag, ".we"}, {31'd0, we}, {31'd0, exp_we});
    chk({tag, ".row"}, {29'd0, row}, r);
    chk({tag, ".col"}, {29'd0, col}, c);
    chk({tag, ".data"}, {16'd0, data}, {16'd0, d});
    chk({tag, ".done"}, {31'd0, done}, {31'd0, exp_done});
  endtask

  task automatic do_start();
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("start.busy", {31'd0, busy}, 32'd1);
  endtask

  initial begin
    rst_n    = 1'b0;
    start    = 1'b0;
    abort    = 1'b0;
    in_valid = 1'b0;
    in_data  = 16'h0;
    tick();
    tick();

    // Reset state
    chk_wr("rst", 1'b0, 0, 0, 16'h0, 1'b0);
    chk("rst.busy", {31'd0, busy}, 32'd0);
    chk("rst.err", {31'd0, err}, 32'd0);
    chk("rst.in_ready", {31'd0, in_ready}, 32'd0);
    rst_n = 1'b1;
    tick();
    chk("idle.busy", {31'd0, busy}, 32'd0);

    // Full tile, back-to-back beats 0..8
    do_start();
    chk("load.in_ready", {31'd0, in_ready}, 32'd1);
    for (int i = 0; i < 9; i++) begin
      in_valid = 1'b1;
      in_data  = 16'(i);
      tick();
      chk_wr("b2b", 1'b1, i / 3, i % 3, 16'(i), i == 8);
    end
    in_valid = 1'b0;
    chk("b2b.busy_done", {31'd0, busy}, 32'd0);
    tick();
    chk_wr("b2b.after", 1'b0, 2, 2, 16'd8, 1'b0);
    chk("b2b.err", {31'd0, err}, 32'd0);

    // Same tile with in_valid toggling; row/col/data hold on idle cycles
    do_start();
    for (int i = 0; i < 9; i++) begin
      in_valid = 1'b1;
      in_data  = 16'(16'h100 + i);
      tick();
      chk_wr("tog", 1'b1, i / 3, i % 3, 16'(16'h100 + i), i == 8);
      in_valid = 1'b0;
      tick();
      chk_wr("tog.gap", 1'b0, i / 3, i % 3, 16'(16'h100 + i), 1'b0);
    end
    chk("tog.busy", {31'd0, busy}, 32'd0);

    // Abort after 4 beats, beat offered with the abort is dropped
    do_start();
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1;
      in_data  = 16'(16'h200 + i);
      tick();
    end
    chk_wr("abt.pre", 1'b1, 1, 0, 16'h203, 1'b0);
    abort   = 1'b1;
    in_data = 16'h2ff;
    #1;
    chk("abt.in_ready", {31'd0, in_ready}, 32'd0);
    tick();
    abort    = 1'b0;
    in_valid = 1'b0;
    chk_wr("abt.edge", 1'b0, 1, 0, 16'h203, 1'b0);
    chk("abt.busy", {31'd0, busy}, 32'd0);
    tick();
    chk("abt.nodone", {31'd0, done}, 32'd0);
    chk("abt.err", {31'd0, err}, 32'd0);
    // Abort in IDLE does nothing
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("abt.idle_busy", {31'd0, busy}, 32'd0);
    do_start();
    for (int i = 0; i < 9; i++) begin
      in_valid = 1'b1;
      in_data  = 16'(16'h10 + i);
      tick();
      chk_wr("abt.new", 1'b1, i / 3, i % 3, 16'(16'h10 + i), i == 8);
    end
    in_valid = 1'b0;
    tick();

    // Word offered in IDLE sets sticky err with no write
    in_valid = 1'b1;
    in_data  = 16'haaaa;
    tick();
    in_valid = 1'b0;
    chk("err.set", {31'd0, err}, 32'd1);
    chk_wr("err.nowr", 1'b0, 2, 2, 16'h18, 1'b0);
    tick();
    chk("err.sticky", {31'd0, err}, 32'd1);
    do_start();
    chk("err.clr", {31'd0, err}, 32'd0);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    // Start and offered word together: start wins
    in_valid = 1'b1;
    tick();
    chk("err.set2", {31'd0, err}, 32'd1);
    start = 1'b1;
    tick();
    start    = 1'b0;
    in_valid = 1'b0;
    chk("err.start_wins", {31'd0, err}, 32'd0);
    chk("err.start_busy", {31'd0, busy}, 32'd1);
    abort = 1'b1;
    tick();
    abort = 1'b0;

    // Reset mid-load after 5 beats
    do_start();
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1;
      in_data  = 16'(16'h300 + i);
      tick();
    end
    chk_wr("rml.pre", 1'b1, 1, 1, 16'h304, 1'b0);
    rst_n = 1'b0;
    #1;
    chk_wr("rml.async", 1'b0, 0, 0, 16'h0, 1'b0);
    chk("rml.busy", {31'd0, busy}, 32'd0);
    in_valid = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    tick();
    chk("rml.nodone", {31'd0, done}, 32'd0);
    chk("rml.idle", {31'd0, busy}, 32'd0);
    do_start();
    in_valid = 1'b1;
    in_data  = 16'h55;
    tick();
    in_valid = 1'b0;
    chk_wr("rml.reload", 1'b1, 0, 0, 16'h55, 1'b0);
    abort = 1'b1;
    tick();
    abort = 1'b0;

    // start during LOAD after 3 beats is ignored
    do_start();
    for (int i = 0; i < 9; i++) begin
      in_valid = 1'b1;
      in_data  = 16'(16'h400 + i);
      start    = (i == 3);
      tick();
      chk_wr("sil", 1'b1, i / 3, i % 3, 16'(16'h400 + i), i == 8);
    end
    start    = 1'b0;
    in_valid = 1'b0;
    // start in DONE is ignored too
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("sil.done_start", {31'd0, busy}, 32'd0);
    chk("sil.after_done", {31'd0, done}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/data_buffer_loader.md
DATA_BUFFER_LOADER -- requirements
Module: data_buffer_loader

Interface
REQ-001 Parameter ROWS, default 3, number of rows in the data buffer tile.
REQ-002 Parameter COLS, default 3, number of columns in the data buffer tile.
REQ-003 Parameter WORD_SIZE, default 16, data word width in bits.
REQ-004 clk  input  1  the single clock; all logic SHALL be rising-edge clocked.
REQ-005 rst_n  input  1  reset, asynchronous and active-low.
REQ-006 start  input  1  one-cycle pulse that begins loading one ROWS x COLS tile.
REQ-007 abort  input  1  cancels an in-progress load.
REQ-008 in_valid  input  1  upstream word valid.
REQ-009 in_data  input  WORD_SIZE  upstream word.
REQ-010 in_ready  output  1  loader accepts a word this cycle; combinational, equal to (state==LOAD && !abort).
REQ-011 we  output  1  write enable to the data buffer, registered.
REQ-012 row  output  ROWS  write row address to the data buffer, registered (width matches the buffer port).
REQ-013 col  output  COLS  write column address to the data buffer, registered.
REQ-014 data  output  WORD_SIZE  write data to the data buffer, registered.
REQ-015 busy  output  1  high while state is LOAD.
REQ-016 done  output  1  one-cycle pulse when the last tile word has been written.
REQ-017 err  output  1  sticky: a word was offered while the loader was not accepting.

Function
REQ-018 The FSM SHALL have states IDLE, LOAD and DONE.
REQ-019 IDLE -> LOAD on start; row and column counters SHALL clear to 0 on that transition.
REQ-020 A beat SHALL be accepted when in_valid && in_ready.
REQ-021 On an accepted beat, the next cycle SHALL show we=1, row/col equal to the counter values at acceptance, and data equal to in_data (latency one cycle).
REQ-022 In every cycle without an accepted beat, we SHALL be 0, and row, col and data SHALL hold their last values.
REQ-023 The counters SHALL advance in raster order: col increments; when col==COLS-1, col wraps to 0 and row increments.
REQ-024 The beat accepted at (ROWS-1, COLS-1) SHALL cause LOAD -> DONE; the counters SHALL not advance past the last address.
REQ-025 DONE SHALL last exactly one cycle, coincide with the final we=1 cycle with done=1, and then go to IDLE.
REQ-026 start while in LOAD or DONE SHALL be ignored.
REQ-027 abort in LOAD SHALL return to IDLE next cycle and clear the counters; done SHALL not pulse; a beat offered in the same cycle SHALL not be accepted (abort wins).
REQ-028 abort in IDLE or DONE SHALL have no effect.
REQ-029 err SHALL set when in_valid=1 and state!=LOAD, and SHALL clear only on an accepted start or on reset.
REQ-030 Back-to-back accepted beats SHALL sustain one write per cycle with no bubbles.
REQ-031 If start and the setting condition for err occur in the same cycle, start clears err first and the set condition is ignored.

Reset
REQ-032 On rst_n=0, asynchronously: state=IDLE, counters=0, we=0, row=0, col=0, data=0, busy=0, done=0, err=0.
REQ-033 Reset asserted mid-load SHALL abandon the tile, with no done pulse after release.
REQ-034 After rst_n deasserts, the loader SHALL wait in IDLE for start.

Structure
REQ-035 The FSM state enum and default ROWS/COLS/WORD_SIZE constants SHALL live in a shared package, bisr_pkg, reused by data_buffer.
REQ-036 The raster row/col counter SHALL be one sub-module, raster_counter (clear, advance, last flag).
REQ-037 Outputs we/row/col/data SHALL connect directly to the data_buffer write port, with no glue logic.

Verification
REQ-038 Reset, then start, then 9 consecutive beats with data 0..8 -> writes at (0,0)..(2,2) with data 0..8 on consecutive cycles; done=1 on the cycle of the (2,2) write; busy low after.
REQ-039 Same tile with in_valid toggling every other cycle -> we only on cycles after accepted beats; addresses strictly in raster order; one done.
REQ-040 abort after 4 beats, then start and 9 beats of data 0x10..0x18 -> no done after the abort; the new tile is written from (0,0) with 0x10.
REQ-041 in_valid=1 with data 0xAAAA while IDLE -> err=1, no write; next start -> err=0.
REQ-042 rst_n pulsed low after 5 beats -> all outputs 0 immediately; no done; the next start reloads from (0,0).
REQ-043 start pulsed during LOAD after 3 beats -> ignored; remaining 6 beats go to (1,0)..(2,2); one done.
